// File: rtl/sdram_burst_reader_if.sv
// Burst-reader bundle: start/status, EasySDRAM command and readout ports, output stream.
// slave is the reader's view; master is the view of the controller/consumer side.
interface sdram_burst_reader_if;
    logic        start;
    logic [24:0] startAddr;
    logic [10:0] length;
    logic        busy;
    logic        done;
    logic        cmdWrite;
    logic        cmdFull;
    logic        cmdIsWrite;
    logic [24:0] cmdAddress;
    logic [1:0]  cmdWriteMask;
    logic [15:0] cmdWriteData;
    logic        readValid;
    logic [24:0] raddr;
    logic [15:0] rdata;
    logic        outValid;
    logic [15:0] outData;
    logic        outReady;

    modport slave (
        input  start, startAddr, length, cmdFull, readValid, raddr, rdata, outReady,
        output busy, done, cmdWrite, cmdIsWrite, cmdAddress, cmdWriteMask, cmdWriteData,
               outValid, outData
    );

    modport master (
        output start, startAddr, length, cmdFull, readValid, raddr, rdata, outReady,
        input  busy, done, cmdWrite, cmdIsWrite, cmdAddress, cmdWriteMask, cmdWriteData,
               outValid, outData
    );
endinterface

// File: rtl/sdram_burst_reader.sv
// Sequential-burst read engine in front of EasySDRAM: issues consecutive reads,
// collects in-order readouts in a FWFT buffer and streams them out.
module sdram_burst_reader #(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    sdram_burst_reader_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] INF_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t      r_state, w_next;
    logic [24:0] r_issueAddr, r_expAddr;
    logic [10:0] r_issueLeft, r_recvLeft, r_outLeft;
    logic [AW:0] r_inflight, r_wptr, r_rptr;
    logic [15:0] r_mem [DEPTH];
    logic        r_doneHs;

    logic w_start, w_issue, w_accept, w_pop, w_lastPop, w_empty, w_full;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign w_start   = (r_state == IDLE) && bus.start;
    assign w_issue   = (r_state == RUN) && (r_issueLeft != '0) && !bus.cmdFull &&
                       (r_inflight < INF_MAX);
    assign w_accept  = (r_state != IDLE) && bus.readValid && (r_recvLeft != '0) &&
                       (bus.raddr == r_expAddr);
    assign w_pop     = !w_empty && bus.outReady;
    assign w_lastPop = w_pop && (r_outLeft == 11'd1);

    // A zero-length burst finishes combinationally in its single FLUSH cycle;
    // a normal burst reports done the cycle after its final handshake.
    assign bus.busy         = (r_state != IDLE);
    assign bus.done         = r_doneHs || ((r_state == FLUSH) && (r_outLeft == '0));
    assign bus.cmdWrite     = w_issue;
    assign bus.cmdIsWrite   = 1'b0;
    assign bus.cmdAddress   = r_issueAddr;
    assign bus.cmdWriteMask = 2'b11;
    assign bus.cmdWriteData = '0;
    assign bus.outValid     = !w_empty;
    assign bus.outData      = r_mem[r_rptr[AW-1:0]];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_next = (bus.length == '0) ? FLUSH : RUN;
            RUN:   if (w_lastPop) w_next = IDLE;
                   else if (r_issueLeft == '0) w_next = FLUSH;
            FLUSH: if ((r_outLeft == '0) || w_lastPop) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issueAddr <= '0;
            r_expAddr   <= '0;
            r_issueLeft <= '0;
            r_recvLeft  <= '0;
            r_outLeft   <= '0;
            r_inflight  <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_doneHs    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_doneHs <= w_lastPop;
            if (w_start) begin
                r_issueAddr <= bus.startAddr;
                r_expAddr   <= bus.startAddr;
                r_issueLeft <= bus.length;
                r_recvLeft  <= bus.length;
                r_outLeft   <= bus.length;
            end else begin
                if (w_issue) begin
                    r_issueAddr <= r_issueAddr + 25'd1;
                    r_issueLeft <= r_issueLeft - 11'd1;
                end
                if (w_accept) begin
                    r_expAddr  <= r_expAddr + 25'd1;
                    r_recvLeft <= r_recvLeft - 11'd1;
                    r_wptr     <= r_wptr + PTR_ONE;
                end
                if (w_pop) begin
                    r_outLeft <= r_outLeft - 11'd1;
                    r_rptr    <= r_rptr + PTR_ONE;
                end
            end
            case ({w_issue, w_pop})
                2'b10:   r_inflight <= r_inflight + PTR_ONE;
                2'b01:   r_inflight <= r_inflight - PTR_ONE;
                default: ;
            endcase
        end
    end

    // Credits bound inflight to DEPTH, so a push into a full buffer is a design error.
    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_wptr[AW-1:0]] <= bus.rdata;
        if (!rst) assert (!(w_accept && w_full));
    end
endmodule
